cpu_mem_arbiter: RTL and testbench

Two-port to one-port memory arbiter between the multicycle CPU core and the shared memory. The core exposes separate instruction-fetch and data channels; this block merges them onto a single valid/ready request channel with one outstanding transaction. It latches the request, routes the read response back to the owning channel, and keeps grant and conflict counters for the performance-counter bank.

---
 rtl/cpu_mem_arb_pkg.sv | 13 +
 rtl/cpu_mem_arbiter_rr_arbiter2.sv | 32 +++
 rtl/cpu_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_arb_pkg.sv
// Shared types for the CPU/memory arbiter: one-hot FSM encoding and owner tags.
package cpu_mem_arb_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE = 3'b001,
        ARB_REQ  = 3'b010,
        ARB_RESP = 3'b100
    } arb_state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

endpackage

// File: rtl/cpu_mem_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter; bit 0 is the instruction port, bit 1 the data port.
module rr_arbiter2
    import cpu_mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] grant
);

    logic last_grant;

    // On a tie, favour whichever port did not win the previous grant.
    always_comb begin
        grant = '0;
        if (req == 2'b11) begin
            grant = (last_grant == OWN_DATA) ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= OWN_DATA;
        end else if (grant_en && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Merges the core's fetch and data channels onto one memory request channel,
// one outstanding transaction at a time, with grant/conflict counters.
module cpu_mem_arbiter
    import cpu_mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic [ADDR_W-1:0]   PC,
    input  logic                Inst_Req_Valid,
    output logic                Inst_Req_Ready,
    output logic [DATA_W-1:0]   Instruction,
    output logic                Inst_Valid,
    input  logic                Inst_Ready,

    input  logic [ADDR_W-1:0]   Address,
    input  logic                MemWrite,
    input  logic                MemRead,
    input  logic [DATA_W-1:0]   Write_data,
    input  logic [DATA_W/8-1:0] Write_strb,
    output logic                Mem_Req_Ready,
    output logic [DATA_W-1:0]   Read_data,
    output logic                Read_data_Valid,
    input  logic                Read_data_Ready,

    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic                mem_ren,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_rdata_valid,
    output logic                mem_rdata_ready,

    output logic [31:0]         inst_grant_cnt,
    output logic [31:0]         data_grant_cnt,
    output logic [31:0]         conflict_cnt
);

    arb_state_t state, next_state;

    logic                owner;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic                ren_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;

    logic       i_req, d_req;
    logic [1:0] grant;
    logic       in_idle;

    assign i_req   = Inst_Req_Valid;
    assign d_req   = MemRead | MemWrite;
    assign in_idle = (state == ARB_IDLE);

    rr_arbiter2 u_rr (
        .clk      (clk),
        .resetn   (resetn),
        .req      ({d_req, i_req}),
        .grant_en (in_idle),
        .grant    (grant)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A simultaneous read+write from the data port is treated as a write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner   <= OWN_INST;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            ren_q   <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (in_idle && (grant != 2'b00)) begin
            if (grant[1]) begin
                owner   <= OWN_DATA;
                addr_q  <= Address;
                wen_q   <= MemWrite;
                ren_q   <= ~MemWrite;
                wdata_q <= Write_data;
                wstrb_q <= Write_strb;
            end else begin
                owner   <= OWN_INST;
                addr_q  <= PC;
                wen_q   <= 1'b0;
                ren_q   <= 1'b1;
                wdata_q <= '0;
                wstrb_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_grant_cnt <= '0;
            data_grant_cnt <= '0;
            conflict_cnt   <= '0;
        end else if (in_idle) begin
            if (grant[0]) inst_grant_cnt <= inst_grant_cnt + 32'd1;
            if (grant[1]) data_grant_cnt <= data_grant_cnt + 32'd1;
            if (i_req && d_req) conflict_cnt <= conflict_cnt + 32'd1;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wen   = wen_q;
    assign mem_ren   = ren_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;

    // Upstream handshakes are only exposed to the owner, and only in the matching state.
    always_comb begin
        next_state      = state;
        mem_req_valid   = 1'b0;
        Inst_Req_Ready  = 1'b0;
        Mem_Req_Ready   = 1'b0;
        Instruction     = '0;
        Inst_Valid      = 1'b0;
        Read_data       = '0;
        Read_data_Valid = 1'b0;
        mem_rdata_ready = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (grant != 2'b00) next_state = ARB_REQ;
            end
            ARB_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    if (owner == OWN_INST) Inst_Req_Ready = 1'b1;
                    else                   Mem_Req_Ready  = 1'b1;
                    next_state = ren_q ? ARB_RESP : ARB_IDLE;
                end
            end
            ARB_RESP: begin
                if (owner == OWN_INST) begin
                    Instruction     = mem_rdata;
                    Inst_Valid      = mem_rdata_valid;
                    mem_rdata_ready = Inst_Ready;
                end else begin
                    Read_data       = mem_rdata;
                    Read_data_Valid = mem_rdata_valid;
                    mem_rdata_ready = Read_data_Ready;
                end
                if (mem_rdata_valid && mem_rdata_ready) next_state = ARB_IDLE;
            end
            default: next_state = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: fetches, writes, ties, backpressure and async reset.
module tb_cpu_mem_arbiter;

    logic        clk;
    logic        resetn;
    logic [31:0] pc;
    logic        inst_req_valid;
    logic        inst_req_ready;
    logic [31:0] instruction;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] address;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] write_data;
    logic [3:0]  write_strb;
    logic        mem_req_ready_up;
    logic [31:0] read_data;
    logic        read_data_valid;
    logic        read_data_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic        mem_ren;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_rdata;
    logic        mem_rdata_valid;
    logic        mem_rdata_ready;
    logic [31:0] inst_grant_cnt;
    logic [31:0] data_grant_cnt;
    logic [31:0] conflict_cnt;

    int testsRun = 0;
    int testsFailed = 0;

    cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .PC              (pc),
        .Inst_Req_Valid  (inst_req_valid),
        .Inst_Req_Ready  (inst_req_ready),
        .Instruction     (instruction),
        .Inst_Valid      (inst_valid),
        .Inst_Ready      (inst_ready),
        .Address         (address),
        .MemWrite        (mem_write),
        .MemRead         (mem_read),
        .Write_data      (write_data),
        .Write_strb      (write_strb),
        .Mem_Req_Ready   (mem_req_ready_up),
        .Read_data       (read_data),
        .Read_data_Valid (read_data_valid),
        .Read_data_Ready (read_data_ready),
        .mem_addr        (mem_addr),
        .mem_wen         (mem_wen),
        .mem_ren         (mem_ren),
        .mem_wdata       (mem_wdata),
        .mem_wstrb       (mem_wstrb),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_rdata       (mem_rdata),
        .mem_rdata_valid (mem_rdata_valid),
        .mem_rdata_ready (mem_rdata_ready),
        .inst_grant_cnt  (inst_grant_cnt),
        .data_grant_cnt  (data_grant_cnt),
        .conflict_cnt    (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic iv, input logic [31:0] fetch_pc,
                                 input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb);
        inst_req_valid = iv;
        pc             = fetch_pc;
        mem_read       = rd;
        mem_write      = wr;
        address        = addr;
        write_data     = wdata;
        write_strb     = wstrb;
        #1;
    endtask

    // Called in the first REQ cycle of a read; leaves the arbiter back in IDLE.
    task automatic serveRead(input string tag, input logic is_data, input logic [31:0] exp_addr,
                             input logic [31:0] rdata);
        checkOutput({tag, "_req_valid"}, 32'(mem_req_valid), 32'd1);
        checkOutput({tag, "_ren"}, 32'(mem_ren), 32'd1);
        checkOutput({tag, "_addr"}, mem_addr, exp_addr);
        mem_req_ready = 1'b1;
        #1;
        checkOutput({tag, "_inst_rdy"}, 32'(inst_req_ready), is_data ? 32'd0 : 32'd1);
        checkOutput({tag, "_data_rdy"}, 32'(mem_req_ready_up), is_data ? 32'd1 : 32'd0);
        tick();
        mem_req_ready = 1'b0;
        if (is_data) mem_read = 1'b0;
        else         inst_req_valid = 1'b0;
        mem_rdata       = rdata;
        mem_rdata_valid = 1'b1;
        #1;
        checkOutput({tag, "_inst_valid"}, 32'(inst_valid), is_data ? 32'd0 : 32'd1);
        checkOutput({tag, "_data_valid"}, 32'(read_data_valid), is_data ? 32'd1 : 32'd0);
        checkOutput({tag, "_rdata"}, is_data ? read_data : instruction, rdata);
        tick();
        mem_rdata_valid = 1'b0;
        #1;
    endtask

    initial begin
        resetn          = 1'b0;
        inst_ready      = 1'b1;
        read_data_ready = 1'b1;
        mem_req_ready   = 1'b0;
        mem_rdata       = '0;
        mem_rdata_valid = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        checkOutput("rst_req_valid", 32'(mem_req_valid), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_inst_cnt", inst_grant_cnt, 32'h0);
        checkOutput("rst_conflict", conflict_cnt, 32'h0);
        resetn = 1'b1;
        tick();

        // Instruction-only fetch with a two-cycle memory response
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("t1_idle_no_req", 32'(mem_req_valid), 32'd0);
        tick();
        checkOutput("t1_inst_cnt", inst_grant_cnt, 32'd1);
        checkOutput("t1_wen", 32'(mem_wen), 32'd0);
        mem_req_ready = 1'b1;
        #1;
        checkOutput("t1_inst_rdy", 32'(inst_req_ready), 32'd1);
        tick();
        mem_req_ready  = 1'b0;
        inst_req_valid = 1'b0;
        #1;
        checkOutput("t1_wait_valid", 32'(inst_valid), 32'd0);
        checkOutput("t1_wait_reqv", 32'(mem_req_valid), 32'd0);
        tick();
        mem_rdata       = 32'h00000013;
        mem_rdata_valid = 1'b1;
        #1;
        checkOutput("t1_inst_valid", 32'(inst_valid), 32'd1);
        checkOutput("t1_instruction", instruction, 32'h13);
        checkOutput("t1_rdata_rdy", 32'(mem_rdata_ready), 32'd1);
        tick();
        mem_rdata_valid = 1'b0;
        #1;
        checkOutput("t1_done", 32'(inst_valid), 32'd0);

        // Data byte write
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h204, 32'hAB, 4'b0001);
        tick();
        checkOutput("t2_data_cnt", data_grant_cnt, 32'd1);
        checkOutput("t2_wen", 32'(mem_wen), 32'd1);
        checkOutput("t2_ren", 32'(mem_ren), 32'd0);
        checkOutput("t2_wstrb", 32'(mem_wstrb), 32'd1);
        checkOutput("t2_wdata", mem_wdata, 32'hAB);
        checkOutput("t2_addr", mem_addr, 32'h204);
        mem_req_ready = 1'b1;
        #1;
        checkOutput("t2_data_rdy", 32'(mem_req_ready_up), 32'd1);
        checkOutput("t2_inst_rdy", 32'(inst_req_ready), 32'd0);
        tick();
        mem_req_ready = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        mem_rdata       = 32'hDEADBEEF;
        mem_rdata_valid = 1'b1;
        #1;
        checkOutput("t2_no_resp", 32'(read_data_valid), 32'd0);
        checkOutput("t2_spurious_rdy", 32'(mem_rdata_ready), 32'd0);
        checkOutput("t2_idle_reqv", 32'(mem_req_valid), 32'd0);
        mem_rdata_valid = 1'b0;
        #1;

        // Back-to-back ties: grants alternate inst, data, inst, then the lone data request
        applyStimulus(1'b1, 32'h300, 1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
        tick();
        checkOutput("t3_conf1", conflict_cnt, 32'd1);
        checkOutput("t3_inst_cnt2", inst_grant_cnt, 32'd2);
        serveRead("t3a", 1'b0, 32'h300, 32'h11111111);
        inst_req_valid = 1'b1;
        pc             = 32'h304;
        #1;
        tick();
        checkOutput("t3_conf2", conflict_cnt, 32'd2);
        checkOutput("t3_data_cnt2", data_grant_cnt, 32'd2);
        serveRead("t3b", 1'b1, 32'h400, 32'h22222222);
        mem_read = 1'b1;
        address  = 32'h408;
        #1;
        tick();
        checkOutput("t3_conf3", conflict_cnt, 32'd3);
        checkOutput("t3_inst_cnt3", inst_grant_cnt, 32'd3);
        serveRead("t3c", 1'b0, 32'h304, 32'h33333333);
        tick();
        checkOutput("t3_conf_hold", conflict_cnt, 32'd3);
        checkOutput("t3_data_cnt3", data_grant_cnt, 32'd3);
        serveRead("t3d", 1'b1, 32'h408, 32'h44444444);

        // Backpressure on both the request and the response side
        applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        pc = 32'h5FC;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("t4_hold_valid", 32'(mem_req_valid), 32'd1);
            checkOutput("t4_hold_addr", mem_addr, 32'h500);
            tick();
        end
        mem_req_ready = 1'b1;
        #1;
        checkOutput("t4_inst_rdy", 32'(inst_req_ready), 32'd1);
        tick();
        mem_req_ready   = 1'b0;
        inst_req_valid  = 1'b0;
        inst_ready      = 1'b0;
        mem_rdata       = 32'h0000_0517;
        mem_rdata_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("t4_bp_rdy", 32'(mem_rdata_ready), 32'd0);
            checkOutput("t4_bp_valid", 32'(inst_valid), 32'd1);
            tick();
        end
        inst_ready = 1'b1;
        #1;
        checkOutput("t4_rel_rdy", 32'(mem_rdata_ready), 32'd1);
        checkOutput("t4_rel_data", instruction, 32'h517);
        tick();
        checkOutput("t4_after_valid", 32'(inst_valid), 32'd0);
        mem_rdata_valid = 1'b0;
        #1;

        // Async reset in the middle of a response
        applyStimulus(1'b1, 32'h600, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready   = 1'b0;
        inst_req_valid  = 1'b0;
        mem_rdata       = 32'h0000DEAD;
        mem_rdata_valid = 1'b1;
        #1;
        checkOutput("t5_pre_valid", 32'(inst_valid), 32'd1);
        resetn = 1'b0;
        #1;
        checkOutput("t5_rst_valid", 32'(inst_valid), 32'd0);
        checkOutput("t5_rst_rdy", 32'(mem_rdata_ready), 32'd0);
        checkOutput("t5_rst_instr", instruction, 32'h0);
        checkOutput("t5_rst_addr", mem_addr, 32'h0);
        checkOutput("t5_rst_cnt", inst_grant_cnt, 32'h0);
        mem_rdata_valid = 1'b0;
        resetn = 1'b1;
        #1;
        applyStimulus(1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        checkOutput("t5_new_cnt", inst_grant_cnt, 32'd1);
        serveRead("t5", 1'b0, 32'h700, 32'h00A00093);

        // MemRead and MemWrite together behave as a single write
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h800, 32'h12345678, 4'hF);
        tick();
        checkOutput("t6_wen", 32'(mem_wen), 32'd1);
        checkOutput("t6_ren", 32'(mem_ren), 32'd0);
        checkOutput("t6_wdata", mem_wdata, 32'h12345678);
        checkOutput("t6_data_cnt", data_grant_cnt, 32'd1);
        mem_req_ready = 1'b1;
        #1;
        checkOutput("t6_data_rdy", 32'(mem_req_ready_up), 32'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("t6_pulse_end", 32'(mem_req_ready_up), 32'd0);
        checkOutput("t6_idle_reqv", 32'(mem_req_valid), 32'd0);
        mem_req_ready = 1'b0;
        tick();
        checkOutput("t6_still_idle", 32'(mem_req_ready_up), 32'd0);
        checkOutput("t6_data_cnt_hold", data_grant_cnt, 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
